instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
// Holds the FSM state encoding and PC width helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int unsigned RESET_PC_DEF  = 0;
  localparam int unsigned DEPTH_DEF     = 256;
  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_0000;

  function automatic int unsigned pc_width(
    input int unsigned depth
  );
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned PC_W = pc_width(DEPTH_DEF);

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a synchronous imem, tracks one
// in-flight request, and loads the IF/ID register with squash/halt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned PW = pc_width(DEPTH);
  localparam logic [PW-1:0] PC_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PC_RST  = PW'(RESET_PC);

  state_e          r_state;
  logic [PW-1:0]   pc_q;
  logic [PW-1:0]   req_pc_q;
  logic            req_valid_q;
  logic [31:0]     r_instr;
  logic [PW-1:0]   r_pc;
  logic            r_valid;
  logic [15:0]     r_cnt;

  logic            w_run;
  logic            w_adv;
  logic            w_halt;
  logic [PW-1:0]   w_pc_next;
  logic [PW-1:0]   w_tgt;
  logic            w_unused;

  assign w_run     = (r_state == ST_RUN);
  assign w_adv     = w_run & ~stall & ~redirect;
  assign w_halt    = w_adv & req_valid_q
                   & (imem_data == HALT_WORD);
  assign w_pc_next = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
  assign w_tgt     = redirect_target[PW-1:0];
  assign w_unused  = ^redirect_target[31:PW];

  // While stalled, re-present the pending address so the
  // memory output is valid for it on the release cycle.
  assign imem_addr   = 32'((w_run && stall) ? req_pc_q : pc_q);
  assign if_id_instr = r_instr;
  assign if_id_pc    = 32'(r_pc);
  assign if_id_valid = r_valid;
  assign halted      = (r_state == ST_HALTED);
  assign fetch_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      pc_q        <= PC_RST;
      req_pc_q    <= PC_RST;
      req_valid_q <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_valid     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect) begin
            pc_q        <= w_tgt;
            req_valid_q <= 1'b0;
            r_valid     <= 1'b0;
          end else if (w_halt) begin
            r_valid     <= 1'b0;
            req_valid_q <= 1'b0;
            r_state     <= ST_HALTED;
          end else if (!stall) begin
            r_instr     <= imem_data;
            r_pc        <= req_pc_q;
            r_valid     <= req_valid_q;
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= w_pc_next;
            if (req_valid_q && r_cnt != 16'hFFFF)
              r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_HALTED: begin
          if (start) begin
            pc_q    <= PC_RST;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a synchronous
// behavioural instruction memory.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];
  exp_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        last_hold = 1'b1;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input int i);
    logic [3:0] d;
    d = (i == 0) ? 4'hA : 4'(i);
    return {d, 20'h0, d, d};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 10) ? word_at(i) : 32'h0;
  end

  always @(posedge clk) begin
    imem_data <= (imem_addr < 32'd256) ?
                 mem[imem_addr[7:0]] : 32'h0;
    last_hold = rst | stall | redirect;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input int i);
    exp_t e;
    e.pc    = 32'(i);
    e.instr = word_at(i);
    sb.push_back(e);
  endtask

  // Pops one expected entry per newly loaded valid output.
  always @(negedge clk) begin
    if (if_id_valid && !last_hold) begin
      if (sb.size() == 0) begin
        check("sb_extra", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", 64'(if_id_pc), 64'(e.pc));
        check("sb_instr", 64'(if_id_instr), 64'(e.instr));
      end
    end
  end

  task automatic wait_pc(input int pc, input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (if_id_valid && if_id_pc == 32'(pc)) found = 1'b1;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic wait_halt(input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (halted) found = 1'b1;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_pc", 64'(if_id_pc), 64'd0);
    check("rst_instr", 64'(if_id_instr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;

    // Run 0..9 with a 3-cycle stall at pc 3, then halt.
    for (int i = 0; i < 10; i++) push(i);
    pulse_start();
    n = 0;
    while (!if_id_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_lat", 64'(n), 64'd2);
    wait_pc(3, "reach_pc3");
    check("cnt_pre_stall", 64'(fetch_count), 64'd4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pc", 64'(if_id_pc), 64'd3);
      check("stall_instr", 64'(if_id_instr), 64'h30000033);
      check("stall_valid", 64'(if_id_valid), 64'd1);
      check("stall_addr", 64'(imem_addr), 64'd4);
    end
    stall = 1'b0;
    @(negedge clk);
    check("rel_pc", 64'(if_id_pc), 64'd4);
    check("cnt_post_stall", 64'(fetch_count), 64'd5);
    wait_halt("halt_a");
    check("halt_valid", 64'(if_id_valid), 64'd0);
    check("halt_count", 64'(fetch_count), 64'd10);
    check("halt_pc_hold", 64'(if_id_pc), 64'd9);
    check("sb_drain_a", 64'(sb.size()), 64'd0);
    redirect = 1'b1;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    check("halt_stays", 64'(halted), 64'd1);

    // Restart, redirect to 7 while pc 2 is on IF/ID.
    for (int i = 0; i < 3; i++) push(i);
    pulse_start();
    check("restart_halted", 64'(halted), 64'd0);
    wait_pc(2, "reach_pc2");
    for (int i = 7; i < 10; i++) push(i);
    redirect = 1'b1;
    redirect_target = 32'h0000_0107;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_t1", 64'(if_id_valid), 64'd0);
    @(negedge clk);
    check("redir_t2", 64'(if_id_valid), 64'd0);
    @(negedge clk);
    check("redir_t3", 64'(if_id_valid), 64'd1);
    wait_halt("halt_b");
    check("halt_count_b", 64'(fetch_count), 64'd16);
    check("sb_drain_b", 64'(sb.size()), 64'd0);

    // Redirect beats stall, then reset mid-run.
    push(0);
    push(1);
    pulse_start();
    wait_pc(1, "reach_pc1");
    push(5);
    redirect = 1'b1;
    stall = 1'b1;
    redirect_target = 32'd5;
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    check("redir_over_stall", 64'(if_id_valid), 64'd0);
    check("cnt_c", 64'(fetch_count), 64'd18);
    wait_pc(5, "reach_pc5");
    rst = 1'b1;
    start = 1'b1;
    redirect = 1'b1;
    stall = 1'b1;
    redirect_target = 32'd3;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    redirect = 1'b0;
    check("mid_rst_valid", 64'(if_id_valid), 64'd0);
    check("mid_rst_pc", 64'(if_id_pc), 64'd0);
    check("mid_rst_instr", 64'(if_id_instr), 64'd0);
    check("mid_rst_count", 64'(fetch_count), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    check("mid_rst_addr", 64'(imem_addr), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_addr", 64'(imem_addr), 64'd0);
      check("idle_valid", 64'(if_id_valid), 64'd0);
    end
    stall = 1'b0;
    check("sb_drain_c", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
